// File: rtl/fiber_uart_rx_if.sv
`timescale 1ns/1ps
// Byte handshake between fiber_uart_rx (master) and its consumer (slave).
interface fiber_uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/fiber_uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver with one-byte holding register, frame error and overrun pulses.
// Optional macro FIBER_UART_RX_MAJORITY_EN: 2-of-3 majority voting around each bit centre.
module fiber_uart_rx #(
  parameter int CLKS_PER_BIT = 106
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  fiber_uart_rx_if.master        bus,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // With voting, the start decision moves one cycle later; every later bit inherits the shift.
`ifdef FIBER_UART_RX_MAJORITY_EN
  localparam int START_DECIDE = CLKS_PER_BIT / 2 + 1;
`else
  localparam int START_DECIDE = CLKS_PER_BIT / 2;
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_DECIDE);
  localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic [1:0]       sync_q, sync_d;
  logic             rxs;
  logic             bit_val;

  assign rxs    = sync_q[1];
  assign sync_d = {sync_q[0], rx};

`ifdef FIBER_UART_RX_MAJORITY_EN
  // hist_q[0] is rxs one cycle ago, hist_q[1] two cycles ago.
  logic [1:0] hist_q, hist_d;
  assign hist_d  = {hist_q[0], rxs};
  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end

      START: begin
        if (cnt_q == START_CNT) begin
          cnt_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d     = '0;
          shift_d   = {bit_val, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A consumer taking the old byte on this very edge frees the register for the new one.
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d = '0;
          if (bit_val) begin
            state_d = IDLE;
            if (!valid_q || bus.rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      sync_q      <= 2'b11;
`ifdef FIBER_UART_RX_MAJORITY_EN
      hist_q      <= 2'b11;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      sync_q      <= sync_d;
`ifdef FIBER_UART_RX_MAJORITY_EN
      hist_q      <= hist_d;
`endif
    end
  end

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fiber_uart_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for fiber_uart_rx: directed scenarios plus random frames with random rx_ready.
module tb_fiber_uart_rx;

  localparam int CPB = 106;
`ifdef FIBER_UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Edges from the first START cycle (one edge after IDLE sees rxs=0) to the stop-bit decision.
  localparam int LAT = CPB / 2 + 9 * CPB + MAJ;

  typedef struct {
    logic [7:0] data;
    int         edge_n;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  logic frame_err;
  logic overrun;
  logic busy;
  int   ready_mode;

  fiber_uart_rx_if u_if ();

  fiber_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .bus       (u_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  pend_t      pend[$];
  int         ferr_q[$];
  logic [7:0] exp_q[$];
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame starting just after a rising edge; glitch inverts rx for one cycle at each bit centre.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input logic glitch);
    logic [9:0] bits;
    pend_t      p;
    int         c;
    bits = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    c = cyc;
    if (stop_bit) begin
      p.data   = b;
      p.edge_n = c + 4 + LAT;
      pend.push_back(p);
    end else begin
      ferr_q.push_back(c + 4 + LAT);
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        rx = (glitch && j == CPB / 2 + 1) ? ~bits[k] : bits[k];
        @(posedge clk);
        #1;
      end
    end
    rx = stop_bit;
  endtask

  // Ready driver: 0 = held low, 1 = held high, 2 = random.
  initial begin
    u_if.rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       u_if.rx_ready = 1'b0;
        1:       u_if.rx_ready = 1'b1;
        default: u_if.rx_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Reference model: one-entry holding register fed by the driver's expected delivery edges.
  always @(posedge clk) begin
    pend_t f;
    logic  deliver;
    cyc++;
    m_fe = 1'b0;
    m_ov = 1'b0;
    deliver = 1'b0;
    if (!rst_n) begin
      mv = 1'b0;
      md = 8'h00;
    end else begin
      if (pend.size() > 0 && pend[0].edge_n == cyc) begin
        f = pend.pop_front();
        deliver = 1'b1;
      end
      if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
        void'(ferr_q.pop_front());
        m_fe = 1'b1;
      end
      if (deliver) begin
        if (!mv || u_if.rx_ready) begin
          md = f.data;
          mv = 1'b1;
          exp_q.push_back(f.data);
        end else begin
          m_ov = 1'b1;
        end
      end else if (mv && u_if.rx_ready) begin
        mv = 1'b0;
      end
    end
  end

  // Monitor: compares whenever the DUT or the model shows activity.
  always @(negedge clk) begin
    if (u_if.rx_valid === 1'b1 || mv) begin
      checkOutput("rx_valid", u_if.rx_valid, mv);
      if (mv) checkOutput("rx_data_hold", u_if.rx_data, md);
    end
    if (u_if.rx_valid === 1'b1 && u_if.rx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL scoreboard_byte: got %0h expected none (cycle %0d)", u_if.rx_data, cyc);
      end else begin
        checkOutput("scoreboard_byte", u_if.rx_data, exp_q.pop_front());
      end
    end
    if (frame_err === 1'b1 || m_fe) checkOutput("frame_err", frame_err, m_fe);
    if (overrun === 1'b1 || m_ov) checkOutput("overrun", overrun, m_ov);
  end

  initial begin
    logic [7:0] rb;
    logic       rbad;
    int         gap;
    rx = 1'b1;
    rst_n = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", u_if.rx_valid, 0);
    checkOutput("reset_data", u_if.rx_data, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(10);

    $display("[TB] single byte A5");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    waitCycles(30);
    checkOutput("a5_busy_idle", busy, 0);

    $display("[TB] back-to-back 3C C3 with consumer stalled");
    ready_mode = 0;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    waitCycles(50);
    checkOutput("stalled_valid", u_if.rx_valid, 1);
    ready_mode = 1;
    waitCycles(10);
    checkOutput("released_valid", u_if.rx_valid, 0);

    $display("[TB] framing error then break");
    applyStimulus(8'h55, 1'b0, 1'b0);
    waitCycles(1000);
    checkOutput("break_busy", busy, 1);
    waitCycles(1000);
    rx = 1'b1;
    waitCycles(2 * CPB);
    checkOutput("after_break_busy", busy, 0);
    applyStimulus(8'h12, 1'b1, 1'b0);
    waitCycles(30);

    $display("[TB] 20-cycle glitch");
    rx = 1'b0;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      if (i == 10) checkOutput("glitch_busy_high", busy, 1);
    end
    rx = 1'b1;
    waitCycles(CPB);
    checkOutput("glitch_busy_low", busy, 0);

    $display("[TB] reset during data bit 4 of FF");
    rx = 1'b0;
    waitCycles(CPB);
    rx = 1'b1;
    waitCycles(4 * CPB + CPB / 2);
    checkOutput("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("abort_busy_reset", busy, 0);
    rst_n = 1'b1;
    waitCycles(2 * CPB);
    applyStimulus(8'h81, 1'b1, 1'b0);
    waitCycles(30);

`ifdef FIBER_UART_RX_MAJORITY_EN
    $display("[TB] 81 with single-cycle glitches at every bit centre");
    applyStimulus(8'h81, 1'b1, 1'b1);
    waitCycles(30);
`endif

    $display("[TB] random frames with random rx_ready");
    ready_mode = 2;
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom);
      rbad = ($urandom_range(0, 7) == 0);
      applyStimulus(rb, ~rbad, 1'b0);
      if (rbad) begin
        waitCycles(CPB);
        rx = 1'b1;
        gap = CPB + $urandom_range(0, CPB);
      end else begin
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2 * CPB);
      end
      waitCycles(gap);
    end
    rx = 1'b1;
    ready_mode = 1;
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || pend.size() != 0 || ferr_q.size() != 0); i++) begin
      waitCycles(1);
    end
    waitCycles(5);
    checkOutput("drain_scoreboard", exp_q.size(), 0);
    checkOutput("drain_pending", pend.size(), 0);
    checkOutput("drain_frame_err", ferr_q.size(), 0);
    checkOutput("final_busy", busy, 0);
    checkOutput("final_valid", u_if.rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fiber_uart_rx.md
FIBER_UART_RX -- requirements
Module: fiber_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 106, clock cycles per serial bit (legal range 8..4095).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line (FIBER_RX or DEBUG_RX); idle high.
REQ-005 SHALL have port rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  byte available.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts byte when rx_valid & rx_ready on a rising edge.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized signal rxs.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on rxs=0, SHALL go to START and clear the bit counter (cycle counter starts at 0).
REQ-014 START: at count CLKS_PER_BIT/2 (integer division), SHALL sample; sample 0 -> DATA with counter reset; sample 1 -> IDLE (glitch rejected, no output).
REQ-015 DATA: SHALL sample each bit at count CLKS_PER_BIT-1 (i.e. at bit centre), shift LSB first, 8 bits, then go to STOP.
REQ-016 STOP: at bit centre, sample 1 -> deliver byte and return to IDLE; sample 0 -> pulse frame_err, discard byte, go to BREAK.
REQ-017 BREAK: SHALL stay until rxs=1, then go to IDLE; a low line SHALL NOT start a new frame while in BREAK.
REQ-018 Delivery: rx_valid and rx_data SHALL update on the same edge on which the stop-bit sample is taken (latency CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first rxs=0 cycle).
REQ-019 rx_data SHALL remain stable while rx_valid=1; rx_valid SHALL clear on the edge where rx_valid & rx_ready, unless a new byte is delivered on that same edge.
REQ-020 Delivery with rx_valid=1 and rx_ready=0: SHALL keep the old byte, drop the new one, pulse overrun.
REQ-021 Delivery with rx_valid=1 and rx_ready=1 on the same edge: SHALL load the new byte, keep rx_valid=1, and not pulse overrun.
REQ-022 Back-to-back frames SHALL be received with zero idle bits: IDLE entered after stop-bit centre detects the next start edge.
REQ-023 Cycle counter width SHALL be $clog2(CLKS_PER_BIT) bits, with no wrap inside a bit.

Reset
REQ-024 While rst_n=0 on a rising edge: state=IDLE, counters=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse; the first frame after release SHALL decode correctly.

Configuration
REQ-026 Macro FIBER_UART_RX_MAJORITY_EN defined: every bit (start, data, stop) SHALL be the 2-of-3 majority of rxs sampled at centre-1, centre, centre+1, and the decision SHALL be taken at centre+1 (all latencies +1 cycle).
REQ-027 Macro FIBER_UART_RX_MAJORITY_EN undefined: single sample at centre, with latencies exactly as REQ-018.

Verification
REQ-028 Send 8'hA5 (CLKS_PER_BIT=106) with rx_ready=1 -> one rx_valid cycle, rx_data=8'hA5, no frame_err/overrun.
REQ-029 Send 8'h3C then 8'hC3 back-to-back with rx_ready=0 -> rx_data holds 8'h3C, overrun pulses once at the second stop centre; raise rx_ready -> rx_valid clears.
REQ-030 Send 8'h55 with stop bit forced low, line held low 2000 cycles then high, then send 8'h12 -> frame_err pulses once, no rx_valid for 8'h55, then 8'h12 received.
REQ-031 Drive 20-cycle low glitch on idle rx -> busy returns to 0, no rx_valid, no frame_err.
REQ-032 Assert rst_n=0 for 3 cycles in the middle of data bit 4 of 8'hFF, then send 8'h81 -> only 8'h81 delivered; with MAJORITY_EN, a 1-cycle inverted pulse at each bit centre of 8'h81 -> still 8'h81.
